// File: rtl/gpio_pattern_sequencer.sv
// Local-bus slave that replays a table of GPIO words, each held for a programmable
// number of lb_clk cycles, in one-shot or loop mode.
package gpio_pattern_sequencer_pkg;
  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } lb_slave_t;

  function automatic logic MatchWLB(input lb_slave_t lb, input logic [7:0] addr);
    return lb.wr && (lb.addr == addr);
  endfunction

  function automatic logic MatchRLB(input lb_slave_t lb, input logic [7:0] addr);
    return lb.rd && (lb.addr == addr);
  endfunction
endpackage

module gpio_pattern_sequencer
  import gpio_pattern_sequencer_pkg::*;
#(
  parameter int unsigned NUM    = 10,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned HOLD_W = 16
) (
  input  logic            lb_clk,
  input  logic            rst,
  input  lb_slave_t       xt_lb,
  output logic [31:0]     rdata,
  output logic [NUM-1:0]  seq_data,
  output logic [NUM-1:0]  seq_oe,
  output logic            busy,
  output logic            done_pulse
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            r_state;
  logic [NUM-1:0]    r_pat  [DEPTH];
  logic [HOLD_W-1:0] r_hold [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [HOLD_W-1:0] r_hold_stage;
  logic [LW-1:0]     r_len;
  logic [NUM-1:0]    r_oe;
  logic              r_loop;
  logic [AW-1:0]     r_idx;
  logic [HOLD_W-1:0] r_cnt;
  logic [NUM-1:0]    r_seq_data;
  logic              r_done_pulse;
  logic              r_done_sticky;

  logic              w_busy;
  logic              w_wr_ctrl;
  logic              w_rd_ctrl;
  logic              w_start;
  logic              w_stop;
  logic [LW-1:0]     w_len_in;
  logic [LW-1:0]     w_len_clamp;
  logic              w_last;
  logic [AW-1:0]     w_idx_nxt;

  assign w_busy      = (r_state == S_RUN);
  assign w_wr_ctrl   = MatchWLB(xt_lb, 8'h00);
  assign w_rd_ctrl   = MatchRLB(xt_lb, 8'h00);
  // STOP takes priority when both command bits are set in one write
  assign w_start     = w_wr_ctrl & xt_lb.wdata[0] & ~xt_lb.wdata[1];
  assign w_stop      = w_wr_ctrl & xt_lb.wdata[1];
  assign w_len_in    = xt_lb.wdata[LW-1:0];
  assign w_len_clamp = (w_len_in > LW'(DEPTH)) ? LW'(DEPTH) : w_len_in;
  assign w_last      = ({1'b0, r_idx} == (r_len - LW'(1)));
  assign w_idx_nxt   = r_idx + AW'(1);

  assign seq_data    = r_seq_data;
  assign seq_oe      = r_oe;
  assign busy        = w_busy;
  assign done_pulse  = r_done_pulse;

  always_ff @(posedge lb_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pat[i]  <= '0;
        r_hold[i] <= '0;
      end
      r_wptr       <= '0;
      r_hold_stage <= '0;
      r_len        <= '0;
      r_oe         <= '0;
      r_loop       <= 1'b0;
    end else begin
      if (!w_busy) begin
        if (MatchWLB(xt_lb, 8'h04)) r_wptr <= xt_lb.wdata[AW-1:0];
        if (MatchWLB(xt_lb, 8'h08)) begin
          r_pat[r_wptr]  <= xt_lb.wdata[NUM-1:0];
          r_hold[r_wptr] <= r_hold_stage;
          r_wptr         <= r_wptr + AW'(1);
        end
        if (MatchWLB(xt_lb, 8'h0C)) r_hold_stage <= xt_lb.wdata[HOLD_W-1:0];
        if (MatchWLB(xt_lb, 8'h10)) r_len <= w_len_clamp;
      end
      if (MatchWLB(xt_lb, 8'h14)) r_oe <= xt_lb.wdata[NUM-1:0];
      if (w_wr_ctrl) r_loop <= xt_lb.wdata[2];
    end
  end

  always_ff @(posedge lb_clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_seq_data    <= '0;
      r_done_pulse  <= 1'b0;
      r_done_sticky <= 1'b0;
    end else begin
      r_done_pulse <= 1'b0;
      if (w_rd_ctrl) r_done_sticky <= 1'b0;
      // completion is ordered last so a same-cycle CTRL read cannot lose it
      case (r_state)
        S_IDLE: begin
          if (w_start && (r_len != '0)) begin
            r_state       <= S_RUN;
            r_idx         <= '0;
            r_seq_data    <= r_pat[0];
            r_cnt         <= r_hold[0];
            r_done_sticky <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_stop) begin
            r_state <= S_IDLE;
          end else if (w_start) begin
            r_idx         <= '0;
            r_seq_data    <= r_pat[0];
            r_cnt         <= r_hold[0];
            r_done_sticky <= 1'b0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - HOLD_W'(1);
          end else if (!w_last) begin
            r_idx      <= w_idx_nxt;
            r_seq_data <= r_pat[w_idx_nxt];
            r_cnt      <= r_hold[w_idx_nxt];
          end else if (r_loop) begin
            r_idx      <= '0;
            r_seq_data <= r_pat[0];
            r_cnt      <= r_hold[0];
          end else begin
            r_state       <= S_IDLE;
            r_done_pulse  <= 1'b1;
            r_done_sticky <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (MatchRLB(xt_lb, 8'h00)) rdata = {28'd0, r_done_sticky, r_loop, 1'b0, w_busy};
    if (MatchRLB(xt_lb, 8'h04)) rdata = 32'(r_wptr);
    if (MatchRLB(xt_lb, 8'h0C)) rdata = 32'(r_hold_stage);
    if (MatchRLB(xt_lb, 8'h10)) rdata = 32'(r_len);
    if (MatchRLB(xt_lb, 8'h14)) rdata = 32'(r_oe);
    if (MatchRLB(xt_lb, 8'h18)) rdata = 32'(r_idx);
  end
endmodule
